// File: rtl/accum_feeder.sv
// accum_feeder: buffers a valid/ready sample stream in a small FIFO and hands
// it to the accumulator as en/data strobes, cutting the stream into blocks of
// BLOCK_LEN samples with a one-cycle clear after each block.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | pops allowed; counts samples toward the end of the block
// ST_CLEAR | single cycle after the last sample; no pop, raises out_clr
module accum_feeder #(
   parameter int IN_WIDTH  = 8,
   parameter int DEPTH     = 4,
   parameter int BLOCK_LEN = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [IN_WIDTH-1:0]      in_data_i,
   input  logic                     hold_i,
   output logic                     out_en_o,
   output logic [IN_WIDTH-1:0]      out_data_o,
   output logic                     out_clr_o,
   output logic                     block_done_o,
   output logic [CNT_WIDTH-1:0]     block_count_o,
   output logic [$clog2(DEPTH):0]   fill_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(BLOCK_LEN + 1);

   localparam logic [0:0]    ST_RUN   = 1'b0;
   localparam logic [0:0]    ST_CLEAR = 1'b1;

   localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] LAST_CNT  = SW'(BLOCK_LEN - 1);

   logic [IN_WIDTH-1:0]  mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          fill_q, fill_d;
   logic [0:0]           state_q, state_d;
   logic [SW-1:0]        smp_cnt_q, smp_cnt_d;
   logic                 out_en_q, out_en_d;
   logic [IN_WIDTH-1:0]  out_data_q, out_data_d;
   logic                 out_clr_q, out_clr_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] blk_cnt_q, blk_cnt_d;

   logic push;
   logic pop;
   logic last_smp;

   // The reset term keeps upstream stalled for the whole reset pulse.
   assign in_ready_o = !rst_i && (fill_q != FILL_FULL);
   assign push       = in_valid_i && in_ready_o;
   assign pop        = (state_q == ST_RUN) && (fill_q != '0) && !hold_i;
   assign last_smp   = (smp_cnt_q == LAST_CNT);

   // Next-state: FIFO pointers/occupancy, block segmentation, output strobes.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      state_d    = state_q;
      smp_cnt_d  = smp_cnt_q;
      out_en_d   = 1'b0;
      out_data_d = out_data_q;
      out_clr_d  = 1'b0;
      done_d     = 1'b0;
      blk_cnt_d  = blk_cnt_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         out_en_d   = 1'b1;
         out_data_d = mem_q[rd_ptr_q];
         if (last_smp) begin
            smp_cnt_d = '0;
            done_d    = 1'b1;
            blk_cnt_d = blk_cnt_q + 1'b1;
            state_d   = ST_CLEAR;
         end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
         end
      end

      if (push && !pop) begin
         fill_d = fill_q + 1'b1;
      end else if (pop && !push) begin
         fill_d = fill_q - 1'b1;
      end

      // CLEAR never pops, so out_clr can never coincide with out_en.
      if (state_q == ST_CLEAR) begin
         out_clr_d = 1'b1;
         state_d   = ST_RUN;
      end
   end

   // Sample storage; contents are don't-care after reset because fill gates reads.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         state_q    <= ST_RUN;
         smp_cnt_q  <= '0;
         out_en_q   <= 1'b0;
         out_data_q <= '0;
         out_clr_q  <= 1'b0;
         done_q     <= 1'b0;
         blk_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         state_q    <= state_d;
         smp_cnt_q  <= smp_cnt_d;
         out_en_q   <= out_en_d;
         out_data_q <= out_data_d;
         out_clr_q  <= out_clr_d;
         done_q     <= done_d;
         blk_cnt_q  <= blk_cnt_d;
      end
   end

   assign out_en_o      = out_en_q;
   assign out_data_o    = out_data_q;
   assign out_clr_o     = out_clr_q;
   assign block_done_o  = done_q;
   assign block_count_o = blk_cnt_q;
   assign fill_o        = fill_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Testbench for accum_feeder with a stand-in accumulator and a queue-based
// scoreboard that tracks samples, block boundaries and block sums.
module tb_accum_feeder;

   localparam int IW    = 8;
   localparam int DEPTH = 4;
   localparam int BL    = 4;
   localparam int CW    = 16;
   localparam int FW    = $clog2(DEPTH) + 1;
   localparam int NSOAK = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_data = '0;
   logic          hold = 1'b0;
   logic          out_en;
   logic [IW-1:0] out_data;
   logic          out_clr;
   logic          block_done;
   logic [CW-1:0] block_count;
   logic [FW-1:0] fill;

   accum_feeder #(
      .IN_WIDTH (IW),
      .DEPTH    (DEPTH),
      .BLOCK_LEN(BL),
      .CNT_WIDTH(CW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .hold_i       (hold),
      .out_en_o     (out_en),
      .out_data_o   (out_data),
      .out_clr_o    (out_clr),
      .block_done_o (block_done),
      .block_count_o(block_count),
      .fill_o       (fill)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc     = 0;

   logic [IW-1:0] exp_q [$];
   int            edge_q[$];
   int            ref_cnt    = 0;
   int            ref_sum    = 0;
   int            pend_sum   = 0;
   int            ref_blocks = 0;
   int            n_done     = 0;
   bit            clr_pend   = 0;
   bit            mon_en     = 0;
   bit            lat_chk    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural accumulator downstream: out_clr is OR'd into its reset.
   always @(posedge clk) begin
      if (rst || out_clr) acc <= 0;
      else if (out_en)    acc <= acc + int'(out_data);
   end

   // Monitor and acceptor: outputs are checked mid-cycle, then the sample that
   // the coming edge will accept is recorded.
   always @(negedge clk) begin
      bit      exp_clr;
      logic [IW-1:0] e;
      int      t;
      if (mon_en) begin
         exp_clr  = clr_pend;
         clr_pend = 0;
         check("en_clr_exclusive", out_en && out_clr, 0);
         check("out_clr", out_clr, exp_clr);
         if (exp_clr) check("block_sum", acc, pend_sum);
         if (out_en) begin
            check("model_has_sample", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               t = edge_q.pop_front();
               check("out_data", out_data, e);
               if (lat_chk) check("latency_edges", cyc - t, 1);
               ref_cnt++;
               ref_sum += int'(e);
               if (ref_cnt == BL) begin
                  ref_cnt  = 0;
                  ref_blocks++;
                  pend_sum = ref_sum;
                  ref_sum  = 0;
                  clr_pend = 1;
               end
            end
            check("block_done", block_done, clr_pend);
            check("block_count", block_count, ref_blocks % (1 << CW));
         end else begin
            check("block_done_idle", block_done, 0);
         end
         if (block_done) n_done++;
         check("fill", fill, exp_q.size());
         check("in_ready", in_ready, (!rst && exp_q.size() != DEPTH));
      end
      if (rst) begin
         exp_q.delete();
         edge_q.delete();
         ref_cnt    = 0;
         ref_sum    = 0;
         ref_blocks = 0;
         clr_pend   = 0;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(in_data);
         edge_q.push_back(cyc + 1);
      end
      if (cyc > 90000) begin
         $display("FAIL watchdog: got cycle %0d expected below 90000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   // Called and returning just after a rising edge.
   task automatic send(input logic [IW-1:0] d);
      int   t = 0;
      logic took;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!took && t < 200);
      check("send_accepted", took, 1);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || clr_pend) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_in_time", t < 500, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bit soak_done;
      int d0;

      // Reset then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_en", out_en, 0);
      check("rst_out_clr", out_clr, 0);
      check("rst_block_count", block_count, 0);
      check("rst_fill", fill, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_data", out_data, 0);
      mon_en = 1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Latency and ordering: a sample pops on the edge after its accept.
      lat_chk = 1;
      send(8'd5);
      send(8'd6);
      send(8'd7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("accum_5_6_7", acc, 18);
      lat_chk = 0;
      @(posedge clk);
      #1;

      // Block boundary
      do_reset();
      send(8'd1);
      send(8'd2);
      send(8'd3);
      send(8'd4);
      send(8'd10);
      drain();
      check("boundary_block_count", block_count, 1);

      // Backpressure
      do_reset();
      hold = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) send(IW'(20 + i));
         end
         begin
            repeat (8) @(posedge clk);
            @(negedge clk);
            check("bp_fill_full", fill, DEPTH);
            check("bp_in_ready_low", in_ready, 0);
            @(posedge clk);
            #1 hold = 1'b0;
         end
      join
      drain();
      check("bp_fill_empty", fill, 0);

      // Reset mid-block
      do_reset();
      send(8'd1);
      send(8'd2);
      repeat (3) @(posedge clk);
      #1 hold = 1'b1;
      send(8'd3);
      send(8'd4);
      @(negedge clk);
      check("mid_fill_before", fill, 2);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_fill_after", fill, 0);
      check("mid_no_clr", out_clr, 0);
      @(posedge clk);
      #1 hold = 1'b0;
      d0 = n_done;
      for (int i = 0; i < 4; i++) send(IW'(40 + i));
      drain();
      check("mid_one_block_done", n_done - d0, 1);
      check("mid_block_count", block_count, 1);

      // Random soak
      do_reset();
      soak_done = 0;
      fork
         begin
            for (int i = 0; i < NSOAK; i++) begin
               repeat ($urandom_range(0, 1)) begin
                  @(posedge clk);
                  #1;
               end
               send(IW'($urandom));
            end
            soak_done = 1;
         end
         begin
            while (!soak_done) begin
               @(posedge clk);
               #1 hold = ($urandom_range(0, 3) == 0);
            end
         end
      join
      hold = 1'b0;
      drain();
      check("soak_block_count", block_count, NSOAK / BL);
      check("soak_fill", fill, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/accum_feeder.md
Name: accum_feeder

Overview:
- Upstream stage of `accum`. Buffers a valid/ready sample stream in a small FIFO.
- Presents the samples to the accumulator as `en`/`data_in` strobes, one per cycle at most.
- Segments the stream into blocks of BLOCK_LEN samples. After each block it emits a one-cycle clear so the accumulator restarts from zero.

Parameters:
- IN_WIDTH, 8: sample width; matches `accum` IN_WIDTH.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BLOCK_LEN, 16: samples per block; at least 1.
- CNT_WIDTH, 16: width of `block_count`.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  feeder can accept a sample.
- in_data  input  IN_WIDTH  upstream sample.
- hold  input  1  downstream stall; no pop while high.
- out_en  output  1  drives `accum` en; registered.
- out_data  output  IN_WIDTH  drives `accum` data_in; registered.
- out_clr  output  1  one-cycle accumulator clear; OR'd into `accum` rst at top level.
- block_done  output  1  one-cycle pulse concurrent with the last sample of a block.
- block_count  output  CNT_WIDTH  number of completed blocks.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO emptied, so fill=0.
  - out_en=0, out_data=0, out_clr=0, block_done=0, block_count=0.
  - Sample counter reset to 0; FSM set to RUN.
  - in_ready=0 while rst is high.
  - Reset mid-block discards buffered data and the partial sample count. No out_clr is emitted on reset; the system rst already clears `accum`.
- in_ready = !rst && (fill != DEPTH).
  - Push happens on in_valid && in_ready at posedge.
  - There is no combinational pass-through: a push into a full FIFO is impossible because in_ready=0.
- Pop condition: state==RUN && fill!=0 && !hold.
  - On pop: out_en<=1, out_data<=head, sample counter increments.
  - Otherwise: out_en<=0 and out_data holds its last value.
- Simultaneous push and pop in one cycle is legal at any fill below DEPTH; fill is unchanged.
- Latency: a sample pushed at edge k into an empty FIFO pops at edge k+1, so out_en is high in the cycle after edge k+1. Minimum latency is 2 cycles from accept to visible out_en.
- Throughput: one sample per cycle sustained when hold=0 and upstream is continuous. in_ready remains 1 in that case.
- FIFO pointers: log2(DEPTH) bits, wrap naturally. Ordering is strictly FIFO.
- FSM states:
  - RUN: pops allowed. On the pop that makes sample counter == BLOCK_LEN:
    - block_done<=1 concurrently with that sample's out_en.
    - sample counter<=0; block_count<=block_count+1 (wraps modulo 2^CNT_WIDTH).
    - next state CLEAR.
  - CLEAR: exactly one cycle.
    - out_clr<=1 takes effect in the next cycle; out_en<=0; no pop.
    - Pushes are still accepted.
    - Next state RUN.
- Resulting output timing: the cycle after the last sample's out_en has out_clr=1 and out_en=0. `accum` therefore clears one edge after accumulating the final sample. The block result is valid on `accum` data_out for exactly the cycle in which out_clr is high.
- hold asserted in RUN only blocks pops; counters and FIFO are otherwise unaffected. hold has no effect in CLEAR.
- BLOCK_LEN=1: every pop produces block_done followed by a clear cycle, giving a maximum of one sample per 2 cycles.
- out_en and out_clr are never high in the same cycle.

Test Plan:
- Reset then idle: rst high 2 cycles → out_en=0, out_clr=0, block_count=0, fill=0, in_ready=0 during reset and 1 after.
- Latency/ordering: push 5, 6, 7 back-to-back into the empty FIFO, hold=0 → out_en high for 3 consecutive cycles starting 2 cycles after the first accept, out_data=5,6,7. Downstream `accum` data_out=18 after those three cycles.
- Block boundary (BLOCK_LEN=4): stream 1, 2, 3, 4, 10 continuously →
  - block_done coincides with out_data=4.
  - Next cycle out_clr=1, out_en=0, and `accum` shows 10 in that cycle.
  - Then out_data=10 with out_en=1.
  - block_count=1.
- Backpressure: hold=1 while pushing 6 samples with DEPTH=4 → fill reaches 4, in_ready=0, the last 2 samples are stalled upstream. Release hold → all 6 samples emerge in order and fill returns to 0.
- Reset mid-block: BLOCK_LEN=4, 2 samples popped, 2 buffered, rst pulsed → fill=0, no out_clr. The next 4 samples produce exactly one block_done.
- Random soak: 10000 samples with random in_valid and hold, scoreboard per-block sums → each block sum equals the reference model at the out_clr cycle, and block_count=10000/BLOCK_LEN.
